regfile_read_arbiter: RTL and testbench
=======================================

# regfile_read_arbiter

- Shares the single 32-bit register-file read port, built around `mux16_1`, among four requesters: CPU, sprite engine, VGA scanout and debug.
- Arbitrates round-robin and drives the 4-bit mux select from a register.
- Captures the mux output and returns it to the winning requester tagged with a valid pulse.
- Issues up to one read per cycle, fully pipelined.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, fixed at 4.
- `DATA_W`, 32: register data width.
- `SEL_W`, 4: register index width (16 entries).

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester read request; held until granted.
- `addr`  in  NUM_REQ*SEL_W  per-requester register index; slice i = bits [i*4+3:i*4]; held stable while `req[i]` is high.
- `gnt`  out  NUM_REQ  one-hot grant, combinational, at most one bit high.
- `rvalid`  out  NUM_REQ  one-hot read-data valid, registered, one-cycle pulse.
- `rdata`  out  DATA_W  read data, shared by all requesters, qualified by `rvalid`.
- `mux_sel`  out  SEL_W  registered select to `mux16_1.sel`.
- `mux_out`  in  DATA_W  `mux16_1.out`, combinational from `mux_sel`.

## Operation
- Round-robin pointer `ptr` (2 bits) is the highest-priority requester for the current cycle.
- Winner: the first i with `req[i]=1`, scanning `ptr`, `ptr+1`, … modulo 4 (wrap-around).
- `gnt[winner]=1` in the same cycle. No request means `gnt=0`.
- On a grant edge:
  - `ptr <= winner+1` (mod 4; winner 3 wraps to 0).
  - `mux_sel <= addr[winner]`.
  - Stage-1 tag: `s1_valid <= 1`, `s1_id <= winner`.
- On a no-grant edge: `ptr`, `mux_sel` and `s1_id` hold; `s1_valid <= 0`.
- Stage 2, every edge:
  - `rdata <= mux_out`.
  - `rvalid <= s1_valid ? onehot(s1_id) : 0`.
- A requester deasserts `req` on the cycle after it sees `gnt`, or keeps `req` high to issue back-to-back reads.
- Changing `addr` while `req` is high and ungranted is illegal; the block samples whatever is present at the grant edge.
- `rdata` holds its last value when `rvalid=0`.
- Reset values:
  - `ptr=0`, `mux_sel=0`, `s1_valid=0`, `s1_id=0`.
  - `rvalid=0`, `rdata=0`.
  - `gnt` is combinational from `req` and reset `ptr`.
- Reset mid-operation: in-flight reads are dropped. No `rvalid` is produced for a grant issued before `resetn` fell. Requesters must re-request.

## Timing
- Grant edge T0. `mux_sel` valid after T0. `mux_out` settles in cycle T0+1. `rvalid`/`rdata` are valid in cycle T0+2 (sampled at edge T0+2).
- Latency: 2 cycles from grant edge to data.
- Throughput: 1 read per cycle. Grants to different requesters in consecutive cycles return in the same order, one cycle apart.
- All 4 requesting continuously: grant order 0,1,2,3,0,… with no starvation; worst-case wait is 3 cycles.
- `gnt` depends combinationally on `req`. Requesters must not derive `req` combinationally from `gnt`.

## Configuration
- `REGARB_CPU_PRIORITY_EN` defined:
  - Requester 0 (CPU) wins whenever `req[0]=1`, regardless of `ptr`.
  - `ptr` is not updated on CPU grants.
  - Requesters 1–3 rotate round-robin among themselves whenever `req[0]=0`.
- Undefined: pure round-robin across all four as above.

## Structure
- Package `regarb_pkg`:
  - `NUM_REQ`, `DATA_W`, `SEL_W`.
  - Requester ID constants `REQ_CPU=0`, `REQ_SPRITE=1`, `REQ_VGA=2`, `REQ_DBG=3`.
  - typedef `req_id_t` (2 bits).
- Sub-module `rr_pick`: combinational rotating-priority encoder.
  - Inputs: `req[3:0]`, `base[1:0]`.
  - Outputs: `gnt[3:0]` one-hot, `id[1:0]`, `any`.
  - Reused by the priority variant with `req[0]` masked.
- Top holds `ptr`, the stage-1 registers, and the stage-2 output registers.

## Test plan
- Single read: after reset, `req=0001`, `addr0=5`, `mux_out` model returns 0xA5A50005 for sel 5 → `gnt=0001` at T0, `mux_sel=5` after T0, `rvalid=0001`, `rdata=0xA5A50005` at T0+2.
- Fairness: `req=1111` held for 8 cycles → `gnt` sequence 0001,0010,0100,1000,0001,0010,0100,1000. `rvalid` follows the same sequence 2 cycles later with the matching data.
- Wrap-around: grant requester 3 alone, then `req=1001` → next grant is requester 0 (`ptr` wrapped to 0).
- Reset mid-flight: grant requester 2 at T0, assert `resetn=0` during cycle T0+1 → `rvalid=0` through T0+2, `mux_sel=0`, `ptr=0`.
- With `REGARB_CPU_PRIORITY_EN`: `req=1111` for 4 cycles → `gnt=0001` every cycle. Then `req=1110` → 0010, 0100, 1000.

Source files
------------

// File: rtl/regarb_pkg.sv
// rtl/regarb_pkg.sv - shared constants, types and helpers for the register-file read arbiter
//
// Contents:
//   NUM_REQ, DATA_W, SEL_W   : fixed geometry of the shared read port
//   REQ_CPU..REQ_DBG         : requester IDs (also the bit position in gnt/rvalid)
//   req_id_t                 : 2-bit requester ID type
//   id_to_onehot()           : requester ID -> one-hot requester vector
`timescale 1ns/1ps

package regarb_pkg;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 4;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_CPU    = 2'd0;
    localparam req_id_t REQ_SPRITE = 2'd1;
    localparam req_id_t REQ_VGA    = 2'd2;
    localparam req_id_t REQ_DBG    = 2'd3;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input req_id_t id);
        logic [NUM_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority encoder for four requesters
//
// Ports:
//   req  in  4  request vector
//   base in  2  highest-priority requester; scan order base, base+1, ... mod 4
//   gnt  out 4  one-hot grant (zero when no request)
//   id   out 2  index of the granted requester (don't-care when any=0)
//   any  out 1  at least one request present
`timescale 1ns/1ps

module rr_pick
    import regarb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            base,
    output logic [NUM_REQ-1:0] gnt,
    output req_id_t            id,
    output logic               any
);

    req_id_t idx;

    always_comb begin
        id  = base;
        any = 1'b0;
        idx = base;
        gnt = '0;
        // 2-bit addition wraps naturally, giving the modulo-4 scan order.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = base + req_id_t'(k);
            if (!any && req[idx]) begin
                any = 1'b1;
                id  = idx;
            end
        end
        if (any) begin
            gnt = id_to_onehot(id);
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin arbiter sharing one register-file read port among four requesters
//
// Optional feature: REGARB_CPU_PRIORITY_EN -- requester 0 (CPU) wins whenever it
// requests and does not move the round-robin pointer; requesters 1..3 rotate
// among themselves otherwise. Undefined: pure round-robin over all four.
//
// Ports:
//   clock    in  1        rising-edge clock
//   resetn   in  1        asynchronous active-low reset
//   req      in  4        per-requester read request, held until granted
//   addr     in  16       per-requester register index, slice i = [i*4+3:i*4]
//   gnt      out 4        one-hot grant, combinational
//   rvalid   out 4        one-hot read-data valid, one-cycle pulse
//   rdata    out 32       read data, qualified by rvalid, holds otherwise
//   mux_sel  out 4        registered select to the external 16:1 mux
//   mux_out  in  32       external mux output, combinational from mux_sel
//
// Pipeline: grant edge loads mux_sel and the stage-1 tag; the next edge
// captures mux_out and the tag into rdata/rvalid.
`timescale 1ns/1ps

module regfile_read_arbiter #(
    parameter int NUM_REQ = regarb_pkg::NUM_REQ,
    parameter int DATA_W  = regarb_pkg::DATA_W,
    parameter int SEL_W   = regarb_pkg::SEL_W
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*SEL_W-1:0] addr,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [SEL_W-1:0]         mux_sel,
    input  logic [DATA_W-1:0]        mux_out
);

    // Round-robin pointer and pipeline registers
    regarb_pkg::req_id_t ptr_q, ptr_d;
    logic [SEL_W-1:0]    mux_sel_q, mux_sel_d;
    logic                s1_valid_q, s1_valid_d;
    regarb_pkg::req_id_t s1_id_q, s1_id_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // Picker interface
    logic [NUM_REQ-1:0]  pick_req;
    logic [NUM_REQ-1:0]  pick_gnt;
    regarb_pkg::req_id_t pick_id;
    logic                pick_any;

    // Final arbitration result
    logic [NUM_REQ-1:0]  win_gnt;
    regarb_pkg::req_id_t win_id;
    logic                win_any;
    logic                win_moves_ptr;

    rr_pick u_pick (
        .req  (pick_req),
        .base (ptr_q),
        .gnt  (pick_gnt),
        .id   (pick_id),
        .any  (pick_any)
    );

`ifdef REGARB_CPU_PRIORITY_EN
    // CPU request bypasses rotation; the picker only sees requesters 1..3,
    // so with ptr=0 it naturally starts the scan at requester 1.
    always_comb begin
        pick_req      = {req[NUM_REQ-1:1], 1'b0};
        win_any       = req[regarb_pkg::REQ_CPU] | pick_any;
        win_id        = pick_id;
        win_gnt       = pick_gnt;
        win_moves_ptr = pick_any;
        if (req[regarb_pkg::REQ_CPU]) begin
            win_id        = regarb_pkg::REQ_CPU;
            win_gnt       = regarb_pkg::id_to_onehot(regarb_pkg::REQ_CPU);
            win_moves_ptr = 1'b0;
        end
    end
`else
    always_comb begin
        pick_req      = req;
        win_any       = pick_any;
        win_id        = pick_id;
        win_gnt       = pick_gnt;
        win_moves_ptr = pick_any;
    end
`endif

    always_comb begin
        ptr_d      = ptr_q;
        mux_sel_d  = mux_sel_q;
        s1_id_d    = s1_id_q;
        s1_valid_d = win_any;
        if (win_moves_ptr) begin
            ptr_d = win_id + 2'd1;
        end
        if (win_any) begin
            mux_sel_d = addr[win_id*SEL_W +: SEL_W];
            s1_id_d   = win_id;
        end
        // mux_sel holds on idle cycles, so capturing every edge keeps rdata stable.
        rdata_d  = mux_out;
        rvalid_d = s1_valid_q ? regarb_pkg::id_to_onehot(s1_id_q) : '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr_q      <= '0;
            mux_sel_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            mux_sel_q  <= mux_sel_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign gnt     = win_gnt;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign mux_sel = mux_sel_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - self-checking bench for regfile_read_arbiter
`timescale 1ns/1ps

module tb_regfile_read_arbiter;

    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [15:0] addr;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [31:0] rdata;
    logic [3:0]  mux_sel;
    logic [31:0] mux_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    // Stand-in for the 16:1 register mux: entry k reads 0xA5A5000k.
    function automatic logic [31:0] reg_value(input logic [3:0] sel);
        return 32'hA5A50000 | {28'd0, sel};
    endfunction

    assign mux_out = reg_value(mux_sel);

    regfile_read_arbiter dut (
        .clock   (clock),
        .resetn  (resetn),
        .req     (req),
        .addr    (addr),
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .mux_sel (mux_sel),
        .mux_out (mux_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Winner from the arbitration rule: first requester found scanning from p.
    function automatic int model_winner(input logic [3:0] r, input int p);
        logic [3:0] rr;
        rr = r;
`ifdef REGARB_CPU_PRIORITY_EN
        if (rr[0]) return 0;
        rr[0] = 1'b0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (rr[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Per-negedge history of grants; a read returns two sample points later
    // unless a reset was seen anywhere in between.
    bit         grant_seen [0:4095];
    int         grant_who  [0:4095];
    int         cyc = 0;
    int         last_rst = -10;
    int         m_ptr = 0;
    logic [3:0] m_sel = 4'd0;
    logic [3:0] sel_prev = 4'd0;

    always @(negedge clock) begin
        int         w;
        logic [3:0] e_gnt;
        logic [3:0] e_rv;
        logic [31:0] e_rd;
        logic [3:0] sel_now;
        if (!resetn) begin
            m_ptr           = 0;
            m_sel           = 4'd0;
            last_rst        = cyc;
            grant_seen[cyc] = 1'b0;
            w               = model_winner(req, 0);
            e_gnt           = (w < 0) ? 4'd0 : (4'd1 << w);
            e_rv            = 4'd0;
            e_rd            = 32'd0;
            sel_now         = 4'd0;
        end else begin
            w       = model_winner(req, m_ptr);
            e_gnt   = (w < 0) ? 4'd0 : (4'd1 << w);
            e_rv    = (cyc >= 2 && grant_seen[cyc-2] && last_rst < cyc - 2)
                      ? (4'd1 << grant_who[cyc-2]) : 4'd0;
            e_rd    = (last_rst == cyc - 1) ? 32'd0 : reg_value(sel_prev);
            sel_now = m_sel;
            grant_seen[cyc] = (w >= 0);
            grant_who[cyc]  = w;
            if (w >= 0) begin
                m_sel = addr[w*4 +: 4];
`ifdef REGARB_CPU_PRIORITY_EN
                if (w != 0) m_ptr = (w + 1) % 4;
`else
                m_ptr = (w + 1) % 4;
`endif
            end
        end
        check("model_gnt", {28'd0, gnt}, {28'd0, e_gnt});
        check("model_rvalid", {28'd0, rvalid}, {28'd0, e_rv});
        check("model_rdata", rdata, e_rd);
        check("model_mux_sel", {28'd0, mux_sel}, {28'd0, sel_now});
        sel_prev = sel_now;
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        tick();
        resetn = 1'b0;
        req    = 4'd0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    logic [3:0]  fair_g [8];
    logic [31:0] fair_d [4];

    initial begin
        fair_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        fair_d = '{32'hA5A50003, 32'hA5A50004, 32'hA5A50008, 32'hA5A5000C};
        resetn = 1'b0;
        req    = 4'd0;
        addr   = 16'd0;
        repeat (3) @(negedge clock);
        check("reset_rvalid", {28'd0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_mux_sel", {28'd0, mux_sel}, 32'd0);
        tick();
        resetn = 1'b1;

        // Single read of entry 5 by the CPU
        tick();
        req  = 4'b0001;
        addr = 16'h0005;
        @(negedge clock);
        check("single_gnt", {28'd0, gnt}, 32'h1);
        tick();
        req = 4'd0;
        @(negedge clock);
        check("single_mux_sel", {28'd0, mux_sel}, 32'h5);
        check("single_rvalid_early", {28'd0, rvalid}, 32'h0);
        @(negedge clock);
        check("single_rvalid", {28'd0, rvalid}, 32'h1);
        check("single_rdata", rdata, 32'hA5A50005);

        // Fairness with all four requesting
        do_reset();
        tick();
        req  = 4'hF;
        addr = 16'hC843;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("fair_gnt", {28'd0, gnt}, {28'd0, fair_g[i]});
            if (i >= 2) begin
                check("fair_rvalid", {28'd0, rvalid}, {28'd0, fair_g[i-2]});
                check("fair_rdata", rdata, fair_d[(i-2) % 4]);
            end
            tick();
        end
        req = 4'd0;
        for (int j = 8; j < 10; j++) begin
            @(negedge clock);
            check("fair_rvalid_tail", {28'd0, rvalid}, {28'd0, fair_g[j-2]});
            check("fair_rdata_tail", rdata, fair_d[(j-2) % 4]);
        end

        // Pointer wrap-around after requester 3
        do_reset();
        tick();
        req  = 4'b1000;
        addr = 16'h7002;
        @(negedge clock);
        check("wrap_gnt3", {28'd0, gnt}, 32'h8);
        tick();
        req = 4'b1001;
        @(negedge clock);
        check("wrap_gnt0", {28'd0, gnt}, 32'h1);
        tick();
        req = 4'd0;
        @(negedge clock);
        check("wrap_mux_sel", {28'd0, mux_sel}, 32'h2);

        // Reset while a read is in flight
        do_reset();
        tick();
        req  = 4'b0100;
        addr = 16'h0900;
        @(negedge clock);
        check("rstmid_gnt", {28'd0, gnt}, 32'h4);
        tick();
        req    = 4'd0;
        resetn = 1'b0;
        @(negedge clock);
        check("rstmid_rvalid1", {28'd0, rvalid}, 32'h0);
        check("rstmid_mux_sel", {28'd0, mux_sel}, 32'h0);
        tick();
        @(negedge clock);
        check("rstmid_rvalid2", {28'd0, rvalid}, 32'h0);
        tick();
        resetn = 1'b1;
        tick();
        req = 4'hF;
        @(negedge clock);
        check("rstmid_ptr0", {28'd0, gnt}, 32'h1);
        tick();
        req = 4'd0;

`ifdef REGARB_CPU_PRIORITY_EN
        do_reset();
        tick();
        req  = 4'hF;
        addr = 16'h4321;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("prio_cpu_gnt", {28'd0, gnt}, 32'h1);
            tick();
        end
        req = 4'hE;
        for (int i = 1; i < 4; i++) begin
            @(negedge clock);
            check("prio_rr_gnt", {28'd0, gnt}, 32'h1 << i);
            tick();
        end
        req = 4'd0;
`else
        // Back-to-back reads by one requester
        do_reset();
        tick();
        req  = 4'b0010;
        addr = 16'h00A0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("b2b_gnt", {28'd0, gnt}, 32'h2);
            tick();
        end
        req = 4'd0;
        @(negedge clock);
        check("b2b_rvalid", {28'd0, rvalid}, 32'h2);
        check("b2b_rdata", rdata, 32'hA5A5000A);
`endif

        repeat (4) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
